// File: rtl/validator_path.sv
// Path-obstruction checker: walks from the origin square towards the destination,
// one synchronous board read per square, and reports whether the path is clear.
module validator_path (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_validation,
  input  logic [2:0] piece_x,
  input  logic [2:0] piece_y,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  input  logic       mover_color,
  input  logic [3:0] piece_read,
  output logic [2:0] validate_x,
  output logic [2:0] validate_y,
  output logic       busy,
  output logic       path_complete,
  output logic       path_clear
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        curX_q, curX_d, curY_q, curY_d;
  logic [2:0]        moveX_q, moveX_d, moveY_q, moveY_d;
  logic signed [3:0] stepX_q, stepX_d, stepY_q, stepY_d;
  logic              color_q, color_d;
  logic              zero_q, zero_d;
  logic              clear_q, clear_d;

  logic signed [3:0] dx, dy, adx, ady, stepX, stepY;
  logic [3:0]        firstX, firstY, nextX, nextY;
  logic              isLine, isZero, atDest;

  assign dx     = $signed({1'b0, move_x}) - $signed({1'b0, piece_x});
  assign dy     = $signed({1'b0, move_y}) - $signed({1'b0, piece_y});
  assign adx    = dx[3] ? -dx : dx;
  assign ady    = dy[3] ? -dy : dy;
  assign stepX  = (dx > 4'sd0) ? 4'sd1 : ((dx < 4'sd0) ? -4'sd1 : 4'sd0);
  assign stepY  = (dy > 4'sd0) ? 4'sd1 : ((dy < 4'sd0) ? -4'sd1 : 4'sd0);
  assign isZero = (dx == 4'sd0) && (dy == 4'sd0);
  assign isLine = (dx == 4'sd0) || (dy == 4'sd0) || (adx == ady);
  assign firstX = {1'b0, piece_x} + stepX;
  assign firstY = {1'b0, piece_y} + stepY;
  assign nextX  = {1'b0, curX_q} + stepX_q;
  assign nextY  = {1'b0, curY_q} + stepY_q;
  assign atDest = (curX_q == moveX_q) && (curY_q == moveY_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      curX_q  <= 3'd0;
      curY_q  <= 3'd0;
      moveX_q <= 3'd0;
      moveY_q <= 3'd0;
      stepX_q <= 4'sd0;
      stepY_q <= 4'sd0;
      color_q <= 1'b0;
      zero_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      curX_q  <= curX_d;
      curY_q  <= curY_d;
      moveX_q <= moveX_d;
      moveY_q <= moveY_d;
      stepX_q <= stepX_d;
      stepY_q <= stepY_d;
      color_q <= color_d;
      zero_q  <= zero_d;
      clear_q <= clear_d;
    end
  end

  // A zero move passes through CHECK without reading so its result lands one cycle after start.
  always_comb begin
    state_d = state_q;
    curX_d  = curX_q;
    curY_d  = curY_q;
    moveX_d = moveX_q;
    moveY_d = moveY_q;
    stepX_d = stepX_q;
    stepY_d = stepY_q;
    color_d = color_q;
    zero_d  = zero_q;
    clear_d = clear_q;
    case (state_q)
      IDLE: begin
        if (start_validation) begin
          moveX_d = move_x;
          moveY_d = move_y;
          stepX_d = stepX;
          stepY_d = stepY;
          color_d = mover_color;
          clear_d = 1'b0;
          zero_d  = isZero;
          if (isZero) begin
            state_d = CHECK;
          end else begin
            state_d = FETCH;
            curX_d  = isLine ? firstX[2:0] : move_x;
            curY_d  = isLine ? firstY[2:0] : move_y;
          end
        end
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        if (zero_q) begin
          clear_d = 1'b0;
          state_d = DONE;
        end else if (atDest) begin
          clear_d = (piece_read == 4'b0000) || (piece_read[3] != color_q);
          state_d = DONE;
        end else if (piece_read != 4'b0000) begin
          clear_d = 1'b0;
          state_d = DONE;
        end else begin
          curX_d  = nextX[2:0];
          curY_d  = nextY[2:0];
          state_d = FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign validate_x    = curX_q;
  assign validate_y    = curY_q;
  assign busy          = (state_q != IDLE);
  assign path_complete = (state_q == DONE);
  assign path_clear    = clear_q;

endmodule

// File: tb/tb_validator_path.sv
// Directed bench for validator_path with a synchronous-read board model.
module tb_validator_path;

  logic       clk;
  logic       reset;
  logic       start_validation;
  logic [2:0] piece_x, piece_y, move_x, move_y;
  logic       mover_color;
  logic [3:0] piece_read;
  logic [2:0] validate_x, validate_y;
  logic       busy, path_complete, path_clear;

  logic [3:0] board [8][8];

  int         passCount = 0;
  int         total = 0;
  int         lat;
  int         nAddr;
  logic [5:0] addrs [8];
  logic       clrAt0, busyAt0, clrDone, busyAfter, clrHeld, sawDone;

  validator_path dut (
    .clk              (clk),
    .reset            (reset),
    .start_validation (start_validation),
    .piece_x          (piece_x),
    .piece_y          (piece_y),
    .move_x           (move_x),
    .move_y           (move_y),
    .mover_color      (mover_color),
    .piece_read       (piece_read),
    .validate_x       (validate_x),
    .validate_y       (validate_y),
    .busy             (busy),
    .path_complete    (path_complete),
    .path_clear       (path_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) piece_read <= board[validate_x][validate_y];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clearBoard();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        board[x][y] = 4'b0000;
  endtask

  // Starts one check and records latency (in edges after E0), FETCH addresses and result.
  task automatic runMove(input logic [2:0] px, input logic [2:0] py, input logic [2:0] mx,
                         input logic [2:0] my, input logic color, input bit pulseMid);
    @(negedge clk);
    piece_x = px; piece_y = py; move_x = mx; move_y = my; mover_color = color;
    start_validation = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_validation = 1'b0;
    clrAt0 = path_clear;
    busyAt0 = busy;
    lat = -1;
    nAddr = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (pulseMid && i == 1) begin
        start_validation = 1'b1; move_x = 3'd5; move_y = 3'd1; mover_color = 1'b1;
      end
      if (pulseMid && i == 2) start_validation = 1'b0;
      if (path_complete) begin
        lat = i;
        break;
      end
      if ((i % 2) == 0 && nAddr < 8) begin
        addrs[nAddr] = {validate_x, validate_y};
        nAddr++;
      end
    end
    clrDone = path_clear;
    @(negedge clk);
    busyAfter = busy;
    clrHeld = path_clear;
  endtask

  initial begin
    reset = 1'b0;
    start_validation = 1'b0;
    piece_x = 3'd0; piece_y = 3'd0; move_x = 3'd0; move_y = 3'd0;
    mover_color = 1'b0;
    piece_read = 4'b0000;
    clearBoard();
    repeat (3) @(negedge clk);
    check("rst_vx", validate_x, 3'd0);
    check("rst_vy", validate_y, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", path_complete, 1'b0);
    check("rst_clear", path_clear, 1'b0);
    reset = 1'b1;

    $display("[TB] diagonal clear with start pulsed while busy");
    runMove(3'd0, 3'd0, 3'd3, 3'd3, 1'b0, 1'b1);
    check("diag_busy0", busyAt0, 1'b1);
    check("diag_lat", lat, 6);
    check("diag_naddr", nAddr, 3);
    check("diag_a0", addrs[0], 6'o11);
    check("diag_a1", addrs[1], 6'o22);
    check("diag_a2", addrs[2], 6'o33);
    check("diag_clear", clrDone, 1'b1);
    check("diag_busy_after", busyAfter, 1'b0);
    check("diag_clear_held", clrHeld, 1'b1);

    $display("[TB] straight blocked");
    board[3][4] = 4'b0010;
    runMove(3'd0, 3'd4, 3'd7, 3'd4, 1'b0, 1'b0);
    check("blk_clear_at_start", clrAt0, 1'b0);
    check("blk_lat", lat, 6);
    check("blk_naddr", nAddr, 3);
    check("blk_a0", addrs[0], 6'o14);
    check("blk_a1", addrs[1], 6'o24);
    check("blk_a2", addrs[2], 6'o34);
    check("blk_clear", clrDone, 1'b0);
    clearBoard();

    $display("[TB] destination capture");
    board[7][5] = 4'b0011;
    runMove(3'd7, 3'd7, 3'd7, 3'd5, 1'b1, 1'b0);
    check("cap_lat", lat, 4);
    check("cap_a0", addrs[0], 6'o76);
    check("cap_a1", addrs[1], 6'o75);
    check("cap_clear", clrDone, 1'b1);

    $display("[TB] destination own piece");
    board[7][5] = 4'b1011;
    runMove(3'd7, 3'd7, 3'd7, 3'd5, 1'b1, 1'b0);
    check("own_clear_at_start", clrAt0, 1'b0);
    check("own_lat", lat, 4);
    check("own_clear", clrDone, 1'b0);
    clearBoard();

    $display("[TB] knight shape");
    runMove(3'd1, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0);
    check("kn_lat", lat, 2);
    check("kn_naddr", nAddr, 1);
    check("kn_a0", addrs[0], 6'o22);
    check("kn_clear", clrDone, 1'b1);

    $display("[TB] zero move");
    runMove(3'd4, 3'd4, 3'd4, 3'd4, 1'b0, 1'b0);
    check("zero_busy0", busyAt0, 1'b1);
    check("zero_lat", lat, 1);
    check("zero_noaddr_x", addrs[0][5:3], 3'd2);
    check("zero_noaddr_y", addrs[0][2:0], 3'd2);
    check("zero_clear", clrDone, 1'b0);
    check("zero_busy_after", busyAfter, 1'b0);

    $display("[TB] reset mid-walk");
    @(negedge clk);
    piece_x = 3'd0; piece_y = 3'd0; move_x = 3'd3; move_y = 3'd3; mover_color = 1'b0;
    start_validation = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_validation = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_addr", {validate_x, validate_y}, 6'o22);
    reset = 1'b0;
    #1;
    check("mid_rst_vx", validate_x, 3'd0);
    check("mid_rst_vy", validate_y, 3'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", path_complete, 1'b0);
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (path_complete) sawDone = 1'b1;
    end
    check("mid_no_done", sawDone, 1'b0);
    reset = 1'b1;
    runMove(3'd0, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0);
    check("post_rst_lat", lat, 6);
    check("post_rst_clear", clrDone, 1'b1);

    $display("%0d/%0d checks passed", passCount, total);
    $finish;
  end

endmodule
